// File: rtl/seq_mul_acc.sv
// Sequential unsigned shift-and-add multiplier with optional accumulate into the product register; latency: WIDTH+1 cycles start->done.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, never queued.
module seq_mul_acc #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 accumulate,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic               acc_q;
    logic [2*WIDTH:0]   p;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   p_step;
    logic [2*WIDTH:0]   acc_sum;

    // Upper half is WIDTH+1 bits, so adding the multiplicand can never carry out of P.
    always_comb begin
        upper_sum = p[2*WIDTH:WIDTH];
        if (p[0]) begin
            upper_sum = p[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
        p_step  = {1'b0, upper_sum, p[WIDTH-1:1]};
        acc_sum = {1'b0, p[2*WIDTH-1:0]} + {1'b0, (acc_q ? product : {2*WIDTH{1'b0}})};
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            mcand   <= '0;
            acc_q   <= 1'b0;
            p       <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= a;
                        acc_q <= accumulate;
                        p     <= {{(WIDTH+1){1'b0}}, b};
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    p   <= p_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    product <= acc_sum[2*WIDTH-1:0];
                    ovf     <= acc_sum[2*WIDTH];
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_acc.sv
// Directed bench for seq_mul_acc at WIDTH=8 with hand-computed products.
module tb_seq_mul_acc;

    logic        clk;
    logic        reset;
    logic        start;
    logic        accumulate;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf;

    int total;
    int bad;

    seq_mul_acc #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // inj > 0 pulses an extra start (a=100,b=100) on that busy cycle; it must be dropped.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic iacc, input logic [15:0] ep, input logic eo, input int inj);
        int n;
        int busy_cnt;
        a = ia; b = ib; accumulate = iacc; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (n == inj) begin
                a = 8'd100; b = 8'd100; start = 1'b1;
            end
            step();
            start = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, n - 1, 9);
        chk({tag, "_busy_cycles"}, busy_cnt, 9);
        chk({tag, "_product"}, product, ep);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_busy_at_done"}, busy, 0);
        step();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int extra;
        int done_idx[$];
        logic [15:0] done_prod[$];
        int busy_bad;

        total = 0;
        bad = 0;
        reset = 1'b0;
        start = 1'b0;
        accumulate = 1'b0;
        a = '0;
        b = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_ovf", ovf, 0);
        step();
        reset = 1'b1;
        step();

        run_op("m13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, 0);
        run_op("m255sq", 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0, 0);
        run_op("m255sq_acc", 8'd255, 8'd255, 1'b1, 16'hFC02, 1'b1, 0);
        run_op("zero_a", 8'd0, 8'd200, 1'b0, 16'h0000, 1'b0, 0);
        run_op("m3x4_acc", 8'd3, 8'd4, 1'b1, 16'h000C, 1'b0, 0);
        run_op("ignored_start", 8'd7, 8'd9, 1'b0, 16'h003F, 1'b0, 3);

        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) extra++;
            step();
        end
        chk("ignored_start_no_extra", extra, 0);

        // Async reset in the middle of busy cycle 4, between clock edges.
        a = 8'd50; b = 8'd50; accumulate = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("abort_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        chk("abort_ovf", ovf, 0);
        step();
        step();
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) extra++;
        end
        chk("abort_no_done", extra, 0);

        // Continuous start with accumulate from a cleared product.
        a = 8'd2; b = 8'd3; accumulate = 1'b1; start = 1'b1;
        busy_bad = 0;
        for (int i = 0; i < 33; i++) begin
            step();
            if (done) begin
                done_idx.push_back(i);
                done_prod.push_back(product);
            end
            if (busy == done) busy_bad++;
        end
        start = 1'b0;
        chk("cont_done_count", done_idx.size(), 3);
        if (done_idx.size() == 3) begin
            chk("cont_done0_edge", done_idx[0], 9);
            chk("cont_done1_edge", done_idx[1], 19);
            chk("cont_done2_edge", done_idx[2], 29);
            chk("cont_prod0", done_prod[0], 16'd6);
            chk("cont_prod1", done_prod[1], 16'd12);
            chk("cont_prod2", done_prod[2], 16'd18);
        end
        chk("cont_busy_vs_done", busy_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mul_acc.md
Name: seq_mul_acc

Overview:
- Sequential unsigned shift-and-add multiplier with optional accumulate.
- Sits directly downstream of the dff storage layer. Its operand and partial-product registers are built from dff flops. It consumes registered operands and produces a registered 2*WIDTH result.
- One iteration per clock, with a start/busy/done handshake toward the controlling datapath.

Parameters:
- WIDTH, 8, operand width in bits (2..32). Result width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low. Low clears all state immediately, independent of clk.
- start  input  1  request a new operation. Sampled only in IDLE.
- accumulate  input  1  sampled with start. 1 = add the new product to the current product register; 0 = overwrite it.
- a  input  WIDTH  multiplicand, captured on the accepting edge.
- b  input  WIDTH  multiplier, captured on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN or ACC).
- done  output  1  one-cycle pulse; product/ovf are updated in the same cycle.
- product  output  2*WIDTH  result register. Holds its value until the next done.
- ovf  output  1  carry-out of the accumulate add for the last operation (0 when accumulate=0).

Behaviour:
- Reset (reset=0): state=IDLE, busy=0, done=0, product=0, ovf=0. Internal P, multiplicand and step counter are cleared. This is asynchronous. Asserting reset mid-operation aborts the operation, and no done is produced after release.
- States: IDLE, RUN, ACC.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture a into the multiplicand register and accumulate into the acc flag. Load P (2*WIDTH+1 bits) with upper WIDTH+1 bits = 0 and lower WIDTH bits = b. Clear the counter and go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge:
    - If P[0]=1, add the multiplicand to P[2*WIDTH:WIDTH], which is WIDTH+1 bits wide so there is no loss.
    - Shift P right by 1, using the post-add value.
    - Counter increments.
  - After exactly WIDTH steps, go to ACC.
- ACC:
  - busy=1.
  - On the next edge:
    - product <= P[2*WIDTH-1:0] + (acc ? product : 0), truncated to 2*WIDTH bits.
    - ovf <= carry-out of that add.
    - done <= 1; go to IDLE.
- done is high for exactly the one cycle after the ACC edge. It is cleared on the following edge regardless of start.
- Latency: start sampled at edge 0 -> RUN steps on edges 1..WIDTH -> ACC edge WIDTH+1 -> done/product visible after edge WIDTH+1. busy is high for WIDTH+1 cycles.
- start while busy=1 is ignored and not queued. a, b and accumulate may change freely while busy.
- start=1 in the done cycle (state is IDLE) is accepted. Back-to-back throughput is one result per WIDTH+2 cycles. With accumulate=1, the new operation uses the product just written.
- Operand of zero: the operation still takes the full WIDTH+1 cycles, with no early termination.
- product and ovf change only on the ACC edge or on reset.

Test Plan:
- WIDTH=8. Reset low then high; a=13, b=11, start=1, accumulate=0 for one cycle -> busy=1 for 9 cycles; done pulses 9 cycles after the start edge; product=0x008F, ovf=0.
- a=255, b=255, accumulate=0 -> product=0xFE01, ovf=0. Then a=255, b=255, accumulate=1 -> product=0xFC02, ovf=1 (0x1FC02 truncated).
- a=0, b=200, accumulate=0 -> product=0x0000 after the full 9 cycles. Then a=3, b=4, accumulate=1 -> product=0x000C.
- Start an operation with a=7, b=9; pulse start with a=100, b=100 on cycle 3 of busy -> that start is ignored; product=0x003F; a single done.
- Start a=50, b=50, drive reset=0 on cycle 4 of busy (async, mid-cycle) -> busy, done, product and ovf are 0 immediately. After release, no done appears for 20 cycles.
- Hold start=1 continuously, a=2, b=3, accumulate=1 from the reset state -> done every 10 cycles; product sequence 6, 12, 18; busy low only during each done cycle.
